// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared constants and types for the CP0 exception controller
package cp0_pkg;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // ex_flags bit indices; bit order is also the priority order below the interrupt
    localparam int NUM_EX_FLAGS = 7;
    localparam int FLG_ADEL_IF  = 0;
    localparam int FLG_RI       = 1;
    localparam int FLG_OV       = 2;
    localparam int FLG_SYS      = 3;
    localparam int FLG_BP       = 4;
    localparam int FLG_ADEL_LD  = 5;
    localparam int FLG_ADES     = 6;

    // Cause field bit positions
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        EXC  = 2'd1,
        ERET = 2'd2
    } cp0_state_t;

    // Source for BadVAddr on a take
    typedef enum logic [1:0] {
        BV_NONE = 2'd0,
        BV_PC   = 2'd1,
        BV_DATA = 2'd2
    } bv_sel_t;

endpackage

// File: rtl/cp0_exc_prio.sv
// rtl/cp0_exc_prio.sv - fixed-priority exception/interrupt winner select
// Ports:
//   int_req      in   pending enabled interrupt (highest priority)
//   ex_flags     in   synchronous exception flags from commit
//   take         out  some source is requesting a take
//   exc_code     out  ExcCode of the winner
//   badvaddr_sel out  which value BadVAddr captures for the winner
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic                    int_req,
    input  logic [NUM_EX_FLAGS-1:0] ex_flags,
    output logic                    take,
    output logic [4:0]              exc_code,
    output bv_sel_t                 badvaddr_sel
);

    always_comb begin
        take         = 1'b1;
        exc_code     = EXC_INT;
        badvaddr_sel = BV_NONE;
        if (int_req) begin
            exc_code = EXC_INT;
        end else if (ex_flags[FLG_ADEL_IF]) begin
            exc_code     = EXC_ADEL;
            badvaddr_sel = BV_PC;
        end else if (ex_flags[FLG_RI]) begin
            exc_code = EXC_RI;
        end else if (ex_flags[FLG_OV]) begin
            exc_code = EXC_OV;
        end else if (ex_flags[FLG_SYS]) begin
            exc_code = EXC_SYS;
        end else if (ex_flags[FLG_BP]) begin
            exc_code = EXC_BP;
        end else if (ex_flags[FLG_ADEL_LD]) begin
            exc_code     = EXC_ADEL;
            badvaddr_sel = BV_DATA;
        end else if (ex_flags[FLG_ADES]) begin
            exc_code     = EXC_ADES;
            badvaddr_sel = BV_DATA;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 Cause/EPC/BadVAddr/EXL owner with flush and fetch redirect
// Ports:
//   clk, reset (sync, active-low)
//   ex_valid, ex_flags, ex_pc, ex_bd, ex_badvaddr, eret  commit-stage inputs
//   hw_int, status_ie, status_im                           interrupt sources/masks
//   cause_we, cause_wdata                                  MTC0 Cause (IP[1:0] only)
//   cause, epc, badvaddr, exl                              architectural state
//   flush, redirect_valid, redirect_pc, busy               pipeline control
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          NUM_HW_INT = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ex_valid,
    input  logic [NUM_EX_FLAGS-1:0] ex_flags,
    input  logic [31:0]             ex_pc,
    input  logic                    ex_bd,
    input  logic [31:0]             ex_badvaddr,
    input  logic                    eret,
    input  logic [NUM_HW_INT-1:0]   hw_int,
    input  logic                    status_ie,
    input  logic [7:0]              status_im,
    input  logic                    cause_we,
    input  logic [31:0]             cause_wdata,
    output logic [31:0]             cause,
    output logic [31:0]             epc,
    output logic [31:0]             badvaddr,
    output logic                    exl,
    output logic                    flush,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic                    busy
);

    cp0_state_t            state_q, state_d;
    logic [NUM_HW_INT-1:0] ip_hw_q;
    logic [1:0]            ip_sw_q;
    logic                  bd_q;
    logic [4:0]            exc_code_q;
    logic [31:0]           epc_q;
    logic [31:0]           badvaddr_q;
    logic                  exl_q;

    logic [7:0]  ip;
    logic        int_req;
    logic        prio_take;
    logic [4:0]  prio_code;
    bv_sel_t     prio_bv_sel;
    logic        take_exc;
    logic        take_eret;

    // Only Cause[9:8] are writable by software
    logic unused_cause_wdata;
    assign unused_cause_wdata = ^{cause_wdata[31:10], cause_wdata[7:0]};

    assign ip      = {ip_hw_q, ip_sw_q};
    assign int_req = status_ie & ~exl_q & (|(ip & status_im));

    cp0_exc_prio u_prio (
        .int_req      (int_req),
        .ex_flags     (ex_flags),
        .take         (prio_take),
        .exc_code     (prio_code),
        .badvaddr_sel (prio_bv_sel)
    );

    // Commit-slot inputs only matter in RUN; an exception suppresses a same-cycle ERET
    assign take_exc  = (state_q == RUN) & ex_valid & prio_take;
    assign take_eret = (state_q == RUN) & ex_valid & eret & ~prio_take;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            ip_hw_q    <= '0;
            ip_sw_q    <= 2'b00;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            exl_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_hw_q <= hw_int;
            if (cause_we) begin
                ip_sw_q <= cause_wdata[9:8];
            end
            if (take_exc) begin
                exc_code_q <= prio_code;
                // Nested takes keep the original return point
                if (!exl_q) begin
                    epc_q <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
                    bd_q  <= ex_bd;
                end
                exl_q <= 1'b1;
                case (prio_bv_sel)
                    BV_PC:   badvaddr_q <= ex_pc;
                    BV_DATA: badvaddr_q <= ex_badvaddr;
                    default: ;
                endcase
            end else if (take_eret) begin
                exl_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (state_q)
            RUN: begin
                if (take_exc) begin
                    state_d = EXC;
                end else if (take_eret) begin
                    state_d = ERET;
                end
            end
            EXC: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
                state_d        = RUN;
            end
            ERET: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = epc_q;
                state_d        = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign cause    = {bd_q, 15'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};
    assign epc      = epc_q;
    assign badvaddr = badvaddr_q;
    assign exl      = exl_q;
    assign busy     = (state_q != RUN);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [6:0]  ex_flags;
    logic [31:0] ex_pc;
    logic        ex_bd;
    logic [31:0] ex_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic        status_ie;
    logic [7:0]  status_im;
    logic        cause_we;
    logic [31:0] cause_wdata;
    logic [31:0] cause, epc, badvaddr, redirect_pc;
    logic        exl, flush, redirect_valid, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_flags       (ex_flags),
        .ex_pc          (ex_pc),
        .ex_bd          (ex_bd),
        .ex_badvaddr    (ex_badvaddr),
        .eret           (eret),
        .hw_int         (hw_int),
        .status_ie      (status_ie),
        .status_im      (status_im),
        .cause_we       (cause_we),
        .cause_wdata    (cause_wdata),
        .cause          (cause),
        .epc            (epc),
        .badvaddr       (badvaddr),
        .exl            (exl),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one commit slot for a single cycle, then drop it
    task automatic commit(input logic [6:0] flags, input logic [31:0] pc, input logic bd,
                          input logic [31:0] badv, input logic er);
        ex_valid    = 1'b1;
        ex_flags    = flags;
        ex_pc       = pc;
        ex_bd       = bd;
        ex_badvaddr = badv;
        eret        = er;
        tick();
        ex_valid = 1'b0;
        ex_flags = 7'd0;
        eret     = 1'b0;
    endtask

    task automatic chk_exc(input string tag, input logic [31:0] exp_cause, input logic [31:0] exp_epc);
        chk({tag, ".cause"}, cause, exp_cause);
        chk({tag, ".epc"}, epc, exp_epc);
        chk({tag, ".exl"}, {31'd0, exl}, 32'd1);
        chk({tag, ".flush"}, {31'd0, flush}, 32'd1);
        chk({tag, ".rv"}, {31'd0, redirect_valid}, 32'd1);
        chk({tag, ".rpc"}, redirect_pc, VEC);
    endtask

    task automatic do_eret(input string tag, input logic [31:0] exp_pc);
        commit(7'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk({tag, ".exl"}, {31'd0, exl}, 32'd0);
        chk({tag, ".flush"}, {31'd0, flush}, 32'd1);
        chk({tag, ".rv"}, {31'd0, redirect_valid}, 32'd1);
        chk({tag, ".rpc"}, redirect_pc, exp_pc);
        tick();
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; ex_flags = 7'd0; ex_pc = 32'd0; ex_bd = 1'b0;
        ex_badvaddr = 32'd0; eret = 1'b0; hw_int = 6'd0; status_ie = 1'b0;
        status_im = 8'd0; cause_we = 1'b0; cause_wdata = 32'd0;

        tick();
        tick();
        chk("rst.cause", cause, 32'd0);
        chk("rst.epc", epc, 32'd0);
        chk("rst.exl", {31'd0, exl}, 32'd0);
        chk("rst.flush", {31'd0, flush}, 32'd0);
        chk("rst.rv", {31'd0, redirect_valid}, 32'd0);
        reset = 1'b1;
        tick();

        // Syscall, not in delay slot
        commit(7'h08, 32'h0040_0010, 1'b0, 32'h0, 1'b0);
        chk_exc("sys", 32'h0000_0020, 32'h0040_0010);
        chk("sys.busy", {31'd0, busy}, 32'd1);
        tick();
        chk("sys.back", {31'd0, flush}, 32'd0);
        do_eret("eret1", 32'h0040_0010);

        // Overflow in a delay slot
        commit(7'h04, 32'h0040_0024, 1'b1, 32'h0, 1'b0);
        chk_exc("ov_bd", 32'h8000_0030, 32'h0040_0020);
        tick();
        do_eret("eret2", 32'h0040_0020);

        // Interrupt beats RI; int held until a valid slot
        status_ie = 1'b1; status_im = 8'h04; hw_int = 6'd1;
        tick();
        chk("int.ip", cause, 32'h8000_0430);
        chk("int.hold", {31'd0, busy}, 32'd0);
        commit(7'h02, 32'h0040_0040, 1'b0, 32'h0, 1'b0);
        chk_exc("int", 32'h0000_0400, 32'h0040_0040);
        tick();
        commit(7'h00, 32'h0040_0044, 1'b0, 32'h0, 1'b0);
        chk("int.masked", {31'd0, busy}, 32'd0);
        chk("int.masked.cause", cause, 32'h0000_0400);

        // Nested AdES: EPC kept, BadVAddr from data address
        commit(7'h40, 32'h0040_0050, 1'b0, 32'h1000_0003, 1'b0);
        chk_exc("ades", 32'h0000_0414, 32'h0040_0040);
        chk("ades.bva", badvaddr, 32'h1000_0003);
        hw_int = 6'd0; status_ie = 1'b0;
        tick();
        do_eret("eret3", 32'h0040_0040);

        // AdEL-fetch beats AdEL-load; BadVAddr takes the PC
        commit(7'h21, 32'h0040_0060, 1'b0, 32'h2000_0000, 1'b0);
        chk_exc("adel", 32'h0000_0010, 32'h0040_0060);
        chk("adel.bva", badvaddr, 32'h0040_0060);
        tick();
        do_eret("eret4", 32'h0040_0060);

        // ERET together with Bp: exception wins
        commit(7'h10, 32'h0040_0070, 1'b0, 32'h0, 1'b1);
        chk_exc("bp_eret", 32'h0000_0024, 32'h0040_0070);
        tick();

        // Ov beats Sys while nested
        commit(7'h0C, 32'h0040_0080, 1'b0, 32'h0, 1'b0);
        chk_exc("ov_sys", 32'h0000_0030, 32'h0040_0070);
        chk("ov_sys.bva", badvaddr, 32'h0040_0060);
        tick();

        // MTC0 Cause touches IP[1:0] only
        cause_we = 1'b1; cause_wdata = 32'hFFFF_FFFF;
        tick();
        cause_we = 1'b0;
        chk("mtc0", cause, 32'h0000_0330);

        // Reset during EXC kills the pulse
        commit(7'h08, 32'h0040_0090, 1'b0, 32'h0, 1'b0);
        chk("rstexc.flush", {31'd0, flush}, 32'd1);
        reset = 1'b0;
        tick();
        chk("rstexc.rv", {31'd0, redirect_valid}, 32'd0);
        chk("rstexc.flush0", {31'd0, flush}, 32'd0);
        chk("rstexc.cause", cause, 32'd0);
        chk("rstexc.exl", {31'd0, exl}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rstexc.rv2", {31'd0, redirect_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception/interrupt controller for the CP0 Cause, EPC and BadVAddr registers. Each cycle it collects synchronous exception flags from the pipeline commit point and the hardware/software interrupt lines, and selects one winner by fixed priority. It then updates Cause/EPC/BadVAddr/EXL, flushes the pipeline and redirects fetch to the handler vector. On ERET it redirects fetch back to EPC.

Parameters:
EXC_VECTOR, 32'hBFC00380, handler entry PC
NUM_HW_INT, 6, hardware interrupt lines, mapped to Cause.IP[7:2]

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
ex_valid  in  1  instruction at commit stage valid this cycle
ex_flags  in  7  sync exception flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-load, [6] AdES
ex_pc  in  32  PC of commit instruction
ex_bd  in  1  commit instruction is in a branch delay slot
ex_badvaddr  in  32  faulting data address for AdEL-load/AdES
eret  in  1  ERET at commit stage, qualified by ex_valid
hw_int  in  NUM_HW_INT  level-sensitive interrupt lines
status_ie  in  1  Status.IE
status_im  in  8  Status.IM
cause_we  in  1  MTC0 write to Cause
cause_wdata  in  32  MTC0 data; only bits [9:8] are used
cause  out  32  Cause register: BD[31], IP[15:8], ExcCode[6:2], other bits 0
epc  out  32  EPC register
badvaddr  out  32  BadVAddr register
exl  out  1  Status.EXL, owned here
flush  out  1  one-cycle pipeline flush pulse
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  32  redirect target, valid with redirect_valid
busy  out  1  high while state is not RUN

Behaviour:
- Reset: sampled on posedge clk when reset==0. cause, epc, badvaddr = 0; exl = 0; flush = 0; redirect_valid = 0; redirect_pc = 0; state = RUN. Reset mid-EXC or mid-ERET aborts the sequence and suppresses the pending pulse.
- IP[7:2]: registered copy of hw_int every cycle, including while busy.
- IP[1:0]: loaded from cause_wdata[9:8] when cause_we=1. All other Cause bits ignore MTC0.
- Interrupt pending: int_req = status_ie & ~exl & |(IP & status_im).
- Arbitration applies only in RUN with ex_valid=1. Priority, highest first:
  - int_req (ExcCode 0)
  - AdEL-fetch (4)
  - RI (10)
  - Ov (12)
  - Sys (8)
  - Bp (9)
  - AdEL-load (4)
  - AdES (5)
- Take, latched at the next edge:
  - Cause.ExcCode ← winner code.
  - If exl=0: EPC ← ex_bd ? ex_pc-4 : ex_pc (mod 2^32); Cause.BD ← ex_bd.
  - If exl=1: EPC and BD are unchanged.
  - exl ← 1.
  - BadVAddr ← ex_pc for AdEL-fetch; ← ex_badvaddr for AdEL-load/AdES; unchanged otherwise.
  - State → EXC.
- EXC, 1 cycle: flush=1, redirect_valid=1, redirect_pc=EXC_VECTOR; → RUN.
- ERET: in RUN with ex_valid & eret and no exception taken: exl ← 0, state → ERET.
- ERET state, 1 cycle: flush=1, redirect_valid=1, redirect_pc=epc; → RUN.
- Exception and eret in the same cycle: the exception wins, eret is ignored, and exl stays 1.
- While busy: ex_valid, ex_flags and eret are ignored (pipeline is being flushed); cause_we is still honoured.
- ex_flags with ex_valid=0: ignored. An int_req is held until a valid commit slot arrives.
- Latency: request edge → flush/redirect visible in the next cycle. Back-to-back takes are possible every 2 cycles.

Decomposition:
- Shared package cp0_pkg:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12.
  - ex_flags bit indices.
  - FSM state enum {RUN, EXC, ERET}.
  - Cause field bit positions.
- One sub-module: cp0_exc_prio, a combinational priority encoder. Inputs: int_req, ex_flags. Outputs: take, exc_code, badvaddr_sel.

Test Plan:
1. Reset low 2 cycles → cause=0, epc=0, exl=0, flush=0. Then ex_valid=1, ex_flags[3]=1, ex_pc=32'h0040_0010, ex_bd=0 → next cycle cause[6:2]=8, epc=32'h0040_0010, exl=1, flush=1, redirect_pc=32'hBFC0_0380.
2. Delay slot: ex_flags[2]=1, ex_pc=32'h0040_0024, ex_bd=1 → epc=32'h0040_0020, cause[31]=1, ExcCode=12.
3. Simultaneous: status_ie=1, status_im=8'h04, hw_int[0]=1, ex_flags[1]=1 → ExcCode=0 (interrupt beats RI); a repeat with exl=1 is not taken.
4. Nested: exl=1, epc=32'h0040_0010, then AdES with ex_badvaddr=32'h1000_0003 → ExcCode=5, badvaddr=32'h1000_0003, epc unchanged.
5. ERET: exl=1, epc=32'h0040_0010, ex_valid & eret → exl=0, redirect_pc=32'h0040_0010, flush=1. An ERET with Bp in the same cycle → Bp taken, exl stays 1.
6. cause_we=1, cause_wdata=32'hFFFF_FFFF → only cause[9:8]=2'b11 set. Reset asserted during the EXC cycle → no redirect pulse on the following cycle.
